// File: rtl/bcd_increment_scheduler_pkg.sv
// Shared types and default sizes for the BCD increment scheduler.
package bcd_increment_scheduler_pkg;

  localparam int unsigned DEFAULT_REQUESTERS       = 4;
  localparam int unsigned DEFAULT_PENDING_BITWIDTH = 4;
  localparam int unsigned DEFAULT_CLEAR_CYCLES     = 2;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_ACK   = 3'd2,
    WAIT_DONE  = 3'd3,
    CLEAR      = 3'd4,
    CLEAR_WAIT = 3'd5
  } state_t;

endpackage

// File: rtl/bcd_increment_scheduler_rr_pick.sv
// Round-robin picker: first set bit of mask at or after ptr, wrapping round.
module bcd_increment_scheduler_rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] index
);

  logic [W-1:0] pos;

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    pos   = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      pos = W'((int'(ptr) + k) % int'(N));
      if (mask[pos]) begin
        valid = 1'b1;
        index = pos;
      end
    end
  end

endmodule

// File: rtl/bcd_increment_scheduler.sv
// Shares one handshaked BCD counter among several increment sources.
module bcd_increment_scheduler
  import bcd_increment_scheduler_pkg::*;
#(
  parameter int unsigned REQUESTERS       = DEFAULT_REQUESTERS,
  parameter int unsigned PENDING_BITWIDTH = DEFAULT_PENDING_BITWIDTH,
  parameter int unsigned CLEAR_CYCLES     = DEFAULT_CLEAR_CYCLES,
  parameter int unsigned GRANT_BITWIDTH   = $clog2(REQUESTERS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [REQUESTERS-1:0]     request,
  input  logic                      clear,
  input  logic                      counter_ready,
  output logic                      counter_enable,
  output logic                      counter_clear,
  output logic [GRANT_BITWIDTH-1:0] grant_id,
  output logic                      serviced,
  output logic                      pending_any,
  output logic [REQUESTERS-1:0]     dropped,
  output logic                      busy
);

  localparam int unsigned CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [PENDING_BITWIDTH-1:0] PEND_MAX = '1;

  state_t                      state_q, state_d;
  logic [GRANT_BITWIDTH-1:0]   ptr_q, ptr_d;
  logic [GRANT_BITWIDTH-1:0]   grant_d;
  logic [CLR_W-1:0]            clr_cnt_q, clr_cnt_d;
  logic                        latch_q, latch_d;
  logic                        serviced_d;
  logic                        clear_entry;
  logic [PENDING_BITWIDTH-1:0] pending_q [REQUESTERS];
  logic [PENDING_BITWIDTH-1:0] pending_d [REQUESTERS];
  logic [REQUESTERS-1:0]       dropped_d;
  logic [REQUESTERS-1:0]       nonzero;
  logic                        any_d;
  logic                        pick_valid;
  logic [GRANT_BITWIDTH-1:0]   pick_index;

  // Which sources currently hold a pending increment.
  always_comb begin
    nonzero = '0;
    for (int i = 0; i < int'(REQUESTERS); i++) begin
      nonzero[i] = |pending_q[i];
    end
  end

  bcd_increment_scheduler_rr_pick #(
    .N (REQUESTERS),
    .W (GRANT_BITWIDTH)
  ) u_rr_pick (
    .mask  (nonzero),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .index (pick_index)
  );

  // Next-state logic: grant, enable/ready handshake and clear sequencing.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_id;
    clr_cnt_d   = '0;
    serviced_d  = 1'b0;
    clear_entry = 1'b0;
    case (state_q)
      IDLE: begin
        if (latch_q) begin
          state_d     = CLEAR;
          clear_entry = 1'b1;
        end else if (counter_ready && pick_valid) begin
          grant_d = pick_index;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ptr_d   = (grant_id == GRANT_BITWIDTH'(REQUESTERS - 1)) ? '0
                                                                : grant_id + GRANT_BITWIDTH'(1);
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!counter_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (counter_ready) begin
          serviced_d = 1'b1;
          state_d    = IDLE;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) state_d = CLEAR_WAIT;
        else clr_cnt_d = clr_cnt_q + CLR_W'(1);
      end
      CLEAR_WAIT: begin
        if (counter_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-source pending counts, sticky drop flags and the clear latch.
  always_comb begin
    pending_d = pending_q;
    dropped_d = dropped;
    any_d     = 1'b0;
    latch_d   = clear | (latch_q & ~clear_entry);
    for (int i = 0; i < int'(REQUESTERS); i++) begin
      if (clear_entry) begin
        // Zero on entry to CLEAR; a same-cycle request still counts afterwards.
        pending_d[i] = PENDING_BITWIDTH'(request[i]);
        dropped_d[i] = 1'b0;
      end else if (request[i] && !((state_q == ISSUE) && (grant_id == GRANT_BITWIDTH'(i)))) begin
        if (pending_q[i] == PEND_MAX) dropped_d[i] = 1'b1;
        else pending_d[i] = pending_q[i] + PENDING_BITWIDTH'(1);
      end else if (!request[i] && (state_q == ISSUE) && (grant_id == GRANT_BITWIDTH'(i))) begin
        pending_d[i] = pending_q[i] - PENDING_BITWIDTH'(1);
      end
      any_d = any_d | (|pending_d[i]);
    end
  end

  // State and datapath registers; every output comes straight from a flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      clr_cnt_q      <= '0;
      latch_q        <= 1'b0;
      pending_q      <= '{default: '0};
      counter_enable <= 1'b0;
      counter_clear  <= 1'b0;
      grant_id       <= '0;
      serviced       <= 1'b0;
      pending_any    <= 1'b0;
      dropped        <= '0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      clr_cnt_q      <= clr_cnt_d;
      latch_q        <= latch_d;
      pending_q      <= pending_d;
      counter_enable <= (state_d == ISSUE);
      counter_clear  <= (state_d == CLEAR);
      grant_id       <= grant_d;
      serviced       <= serviced_d;
      pending_any    <= any_d;
      dropped        <= dropped_d;
      busy           <= (state_d != IDLE);
    end
  end

endmodule
